// File: rtl/top_level_filter_pkg.sv
// Shared widths, types and fixed kernel weights for the Level 1 3x3 filter bank.
package top_level_filter_pkg;

    localparam int PIX_W = 9;   // pixels per 3x3 patch
    localparam int N_K   = 9;   // number of kernels
    localparam int W_W   = 8;   // weight width (signed)
    localparam int B_W   = 12;  // bias width (signed)
    localparam int OUT_W = 20;  // accumulator / output width (signed)

    typedef logic signed [OUT_W-1:0] acc_t;
    typedef logic signed [W_W-1:0]   wt_t;
    typedef logic signed [B_W-1:0]   bias_t;

    typedef wt_t   [PIX_W-1:0] w_row_t;
    typedef w_row_t [N_K-1:0]  w_mat_t;
    typedef bias_t [N_K-1:0]   b_vec_t;

    // Center-surround kernels: +8 on the kernel's own pixel, -1 everywhere else.
    function automatic w_mat_t default_weights();
        w_mat_t w;
        for (int k = 0; k < N_K; k++) begin
            for (int i = 0; i < PIX_W; i++) begin
                w[k][i] = (i == k) ? wt_t'(8) : wt_t'(-1);
            end
        end
        return w;
    endfunction

    localparam w_mat_t W = default_weights();
    localparam b_vec_t B = '0;

endpackage

// File: rtl/top_level_filter_kernel_mac.sv
// One fixed 3x3 kernel: binary-gated 9-tap sum of signed weights plus bias.
// Optional ReLU on the result when TOP_LEVEL_FILTER_RELU_EN is defined.
module kernel_mac
    import top_level_filter_pkg::*;
#(
    parameter int K = 0
) (
    input  logic [PIX_W-1:0] x,
    output acc_t             acc
);

    acc_t sum;

    // Accumulate bias plus every weight whose pixel is set, sign-extended to OUT_W.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' so each partial sum is visible to the next tap; the first assignment also acts as the default that prevents latch inference.
        sum = acc_t'(B[K]);
        for (int i = 0; i < PIX_W; i++) begin
            if (x[i]) begin
                sum = sum + acc_t'(W[K][i]);
            end
        end
    end

`ifdef TOP_LEVEL_FILTER_RELU_EN
    // Clamp negative responses to zero.
    assign acc = sum[OUT_W-1] ? '0 : sum;
`else
    assign acc = sum;
`endif

endmodule

// File: rtl/top_level_filter.sv
// Level 1 feature extraction: nine fixed 3x3 kernels over a binary patch.
// Two-stage pipeline: patch register, then per-kernel output registers.
// Build option: TOP_LEVEL_FILTER_RELU_EN clamps negative responses to zero.
module top_level_filter
    import top_level_filter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] X,
    output acc_t             output_0,
    output acc_t             output_1,
    output acc_t             output_2,
    output acc_t             output_3,
    output acc_t             output_4,
    output acc_t             output_5,
    output acc_t             output_6,
    output acc_t             output_7,
    output acc_t             output_8
);

    logic [PIX_W-1:0] x_q;
    acc_t             acc   [N_K];
    acc_t             out_q [N_K];

    for (genvar k = 0; k < N_K; k++) begin : g_kernel
        kernel_mac #(.K(k)) u_mac (
            .x   (x_q),
            .acc (acc[k])
        );
    end

    // Pipeline registers: capture the patch, then register all nine responses together.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the output bank is a set of pipeline registers, not a memory, so every entry is reset to guarantee no stale result leaks out after reset.
            x_q <= '0;
            for (int k = 0; k < N_K; k++) begin
                out_q[k] <= '0;
            end
        end else begin
            x_q <= X;
            for (int k = 0; k < N_K; k++) begin
                out_q[k] <= acc[k];
            end
        end
    end

    assign output_0 = out_q[0];
    assign output_1 = out_q[1];
    assign output_2 = out_q[2];
    assign output_3 = out_q[3];
    assign output_4 = out_q[4];
    assign output_5 = out_q[5];
    assign output_6 = out_q[6];
    assign output_7 = out_q[7];
    assign output_8 = out_q[8];

endmodule

// File: tb/tb_top_level_filter.sv
// Scoreboard bench for top_level_filter: directed patches followed by random
// patches with occasional resets, checked against an arithmetic model.
module tb_top_level_filter;

    logic             clk = 1'b0;
    logic             rst;
    logic [8:0]       X;
    logic signed [19:0] o [9];

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int                 due;
        logic signed [19:0] v [9];
    } exp_t;

    exp_t q [$];
    bit   prev_rst = 1'b0;

    top_level_filter dut (
        .clk      (clk),
        .rst      (rst),
        .X        (X),
        .output_0 (o[0]),
        .output_1 (o[1]),
        .output_2 (o[2]),
        .output_3 (o[3]),
        .output_4 (o[4]),
        .output_5 (o[5]),
        .output_6 (o[6]),
        .output_7 (o[7]),
        .output_8 (o[8])
    );

    always #5 clk = ~clk;

    // Edge counter: after rising edge n this reads n.
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: center-surround response 9*x[k] - popcount(x), optionally rectified.
    function automatic exp_t model(input logic [8:0] x, input int due);
        exp_t e;
        int   pc;
        int   r;
        pc = $countones(x);
        e.due = due;
        for (int k = 0; k < 9; k++) begin
            r = 9 * int'(x[k]) - pc;
`ifdef TOP_LEVEL_FILTER_RELU_EN
            if (r < 0) r = 0;
`endif
            e.v[k] = 20'(r);
        end
        return e;
    endfunction

    function automatic exp_t zeros(input int due);
        exp_t e;
        e.due = due;
        for (int k = 0; k < 9; k++) e.v[k] = '0;
        return e;
    endfunction

    // Drive one cycle of stimulus (called while clk is low) and log expectations.
    task automatic step(input logic [8:0] x, input logic r);
        X   = x;
        rst = r;
        if (r) begin
            // Everything in flight is lost; the coming edge shows zeros.
            q.delete();
            q.push_back(zeros(cyc + 1));
        end else begin
            // First edge after reset shows the response to an all-zero patch.
            if (prev_rst) q.push_back(model(9'h000, cyc + 1));
            q.push_back(model(x, cyc + 2));
        end
        prev_rst = r;
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic signed [19:0] got,
                         input logic signed [19:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, want);
        end
    endtask

    // Monitor: just after each edge, compare outputs with the entry due now.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (q.size() > 0 && q[0].due < cyc) begin
                e = q.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL missed_entry: due cycle %0d never checked (now %0d)", e.due, cyc);
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                for (int k = 0; k < 9; k++) begin
                    check($sformatf("output_%0d", k), o[k], e.v[k]);
                end
            end
        end
    end

    initial begin
        logic [8:0] rx;
        // Reset held with all pixels set: outputs must stay 0.
        step(9'h1FF, 1'b1);
        step(9'h1FF, 1'b1);
        step(9'h1FF, 1'b1);
        // Directed patches.
        step(9'b101010101, 1'b0);
        step(9'h1FF, 1'b0);
        step(9'h000, 1'b0);
        step(9'b000010000, 1'b0);
        // Pipeline then mid-stream reset.
        step(9'h001, 1'b0);
        step(9'h002, 1'b0);
        step(9'h1FF, 1'b0);
        step(9'h001, 1'b0);
        step(9'h002, 1'b0);
        step(9'h000, 1'b1);
        step(9'h1FF, 1'b0);
        step(9'h000, 1'b0);
        // Random patches with occasional reset bursts.
        for (int n = 0; n < 400; n++) begin
            rx = 9'($urandom_range(0, 511));
            step(rx, ($urandom_range(0, 39) == 0));
        end
        step(9'h000, 1'b0);
        // Drain the pipeline.
        repeat (4) @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
